fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO, successor to the fixed 8x32 sync FIFO.
- Generic data width and depth, programmable almost-full/almost-empty thresholds, and an optional first-word-fall-through (FWFT) read mode.
- Correct count update on simultaneous read/write; sticky overflow/underflow error flags.
- Single clock domain; used as the general buffering element between producer/consumer blocks.

Parameters:
- DATA_W, 8, data width in bits (>=1).
- DEPTH, 32, number of entries; power of two, >=4.
- AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL; 0 <= AE_LEVEL < DEPTH.
- AF_LEVEL, 31, almost_full asserted when count >= AF_LEVEL; 0 < AF_LEVEL <= DEPTH.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- wr  in  1  write request.
- rd  in  1  read request.
- data_in  in  DATA_W  write data.
- clr_err  in  1  synchronous clear of overflow/underflow.
- data_out  out  DATA_W  read data.
- valid  out  1  data_out qualifier.
- empty  out  1  count == 0.
- almost_empty  out  1  count <= AE_LEVEL.
- almost_full  out  1  count >= AF_LEVEL.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst low, asynchronous):
  - wptr, rptr and count clear to 0 immediately, regardless of clk.
  - data_out is 0; valid, overflow and underflow are 0.
  - empty=1, full=0; almost_empty=1; almost_full=(AF_LEVEL==0, impossible, so 0).
  - Memory contents are not reset.
  - A reset asserted mid-operation discards all stored data; the first write after reset deassertion lands at address 0.
- Acceptance is evaluated against the state at the clock edge:
  - wr_acc = wr & !full.
  - rd_acc = rd & !empty.
- Write: on wr_acc, mem[wptr] <= data_in; wptr increments modulo DEPTH (natural wrap, $clog2(DEPTH) bits).
- Read: on rd_acc, rptr increments modulo DEPTH.
- Count:
  - +1 if wr_acc & !rd_acc.
  - -1 if rd_acc & !wr_acc.
  - Unchanged if both or neither.
  - Never exceeds DEPTH; never goes below 0.
- Full with wr & rd: read accepted, write rejected, overflow set, count -> DEPTH-1.
- Empty with wr & rd: write accepted, read rejected, underflow set, count -> 1.
- A write never bypasses to the read port in the same cycle.
- Errors:
  - overflow sets on wr & full; underflow sets on rd & empty. Both hold until clr_err=1 or reset.
  - If clr_err and a new error occur in the same cycle, set wins.
  - Rejected operations change no pointer, count or memory.
- Flags: empty, full, almost_* are combinational decodes of the registered count, so they change in the cycle after the causing edge.
- FWFT=0 (standard):
  - On rd_acc, data_out <= mem[rptr] and valid <= 1 for exactly one cycle. Latency: data is on data_out 1 cycle after the read edge.
  - Otherwise valid <= 0 and data_out holds its last value.
- FWFT=1:
  - data_out = mem[rptr] combinationally; valid = !empty.
  - rd acts as acknowledge of the current head; the next word appears the cycle after rd_acc.
  - Write-to-visible latency is 1 cycle: the word is visible after the write edge once count becomes 1.

Test Plan:
- Fill (DATA_W=8, DEPTH=32): reset, write 0x00..0x1F on 32 consecutive cycles -> full=1, count=32, almost_full from count=31; 33rd write of 0xAA -> overflow=1, count stays 32, 0xAA never read.
- Drain in order: from full, read 32 cycles -> data_out 0x00..0x1F in order, each 1 cycle after rd, valid pulses 32 times; empty=1 and almost_empty=1 at count<=1; extra rd -> underflow=1, data_out holds 0x1F; clr_err -> both errors 0.
- Simultaneous rd/wr:
  - At count=5: rd & wr for 10 cycles -> count stays 5, output order preserved.
  - At full: wr & rd -> count 31, overflow=1.
  - At empty: wr & rd -> count 1, underflow=1.
- Wrap-around: interleave 100 writes (0x00..0x63) and reads keeping count at 3 -> pointers wrap 3 times, reads match exactly, no flag glitches.
- FWFT=1: write 0x5A to empty FIFO -> next cycle valid=1, data_out=0x5A with no rd; rd -> following cycle empty=1, valid=0.
- Reset mid-op: with count=10, pull rst low between clock edges -> count=0, empty=1, valid=0 immediately without a clock edge; after release, write 0x11 then read -> returns 0x11.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and optional first-word-fall-through read port.
module fifo_sync_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AE_LEVEL = 1,
    parameter int unsigned AF_LEVEL = 31,
    parameter int unsigned FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     clr_err,
    output logic [DATA_W-1:0]        data_out,
    output logic                     valid,
    output logic                     empty,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wptr_q,  wptr_d;
    logic [AW-1:0]     rptr_q,  rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q,   ovf_d;
    logic              udf_q,   udf_d;
    logic [DATA_W-1:0] dout_q,  dout_d;
    logic              valid_q, valid_d;
    logic              wr_acc,  rd_acc;

    // Status flags decode the registered occupancy only
    assign empty        = (count_q == CW'(0));
    assign full         = (count_q == CW'(DEPTH));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Next-state logic for pointers, occupancy, error flags and read register
    always_comb begin
        wr_acc  = wr & ~full;
        rd_acc  = rd & ~empty;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        valid_d = 1'b0;

        if (wr_acc) wptr_d = wptr_q + AW'(1);
        if (rd_acc) rptr_d = rptr_q + AW'(1);

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A new error in the same cycle as clr_err keeps the flag set
        ovf_d = (wr & full)  | (ovf_q & ~clr_err);
        udf_d = (rd & empty) | (udf_q & ~clr_err);

        if ((FWFT == 0) && rd_acc) begin
            dout_d  = mem[rptr_q];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    // Storage array is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr_q] <= data_in;
    end

    generate
        if (FWFT == 0) begin : g_std
            assign data_out = dout_q;
            assign valid    = valid_q;
        end else begin : g_fwft
            // Head is gated to zero while empty so reset shows data_out = 0
            assign data_out = empty ? '0 : mem[rptr_q];
            assign valid    = ~empty;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed testbench for fifo_sync_param: one standard-read and one FWFT instance.
module tb_fifo_sync_param;

    logic       clk;
    logic       rst;

    logic       wr, rd, clr;
    logic [7:0] din, dout;
    logic       vld, emp, ae, af, ful, ovf, udf;
    logic [5:0] cnt;

    logic       wr1, rd1, clr1;
    logic [7:0] din1, dout1;
    logic       vld1, emp1, ae1, af1, ful1, ovf1, udf1;
    logic [5:0] cnt1;

    int n_checks;
    int n_fail;

    fifo_sync_param #(.DATA_W(8), .DEPTH(32), .AE_LEVEL(1), .AF_LEVEL(31), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .data_in(din), .clr_err(clr),
        .data_out(dout), .valid(vld), .empty(emp), .almost_empty(ae), .almost_full(af),
        .full(ful), .count(cnt), .overflow(ovf), .underflow(udf)
    );

    fifo_sync_param #(.DATA_W(8), .DEPTH(32), .AE_LEVEL(1), .AF_LEVEL(31), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr(wr1), .rd(rd1), .data_in(din1), .clr_err(clr1),
        .data_out(dout1), .valid(vld1), .empty(emp1), .almost_empty(ae1), .almost_full(af1),
        .full(ful1), .count(cnt1), .overflow(ovf1), .underflow(udf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_checks++; if (cnt !== 6'd0)  begin n_fail++; $display("FAIL reset_count got %0d exp 0", cnt); end
        n_checks++; if ({emp, ful, ae, af} !== 4'b1010) begin n_fail++; $display("FAIL reset_flags got %b exp 1010", {emp, ful, ae, af}); end
        n_checks++; if ({vld, ovf, udf} !== 3'b000) begin n_fail++; $display("FAIL reset_vld_err got %b exp 000", {vld, ovf, udf}); end
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h exp 00", dout); end
        n_checks++; if ({vld1, dout1} !== 9'h000) begin n_fail++; $display("FAIL reset_fwft got %b/%h exp 0/00", vld1, dout1); end
        @(negedge clk);
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            wr = 1'b1; din = 8'(i);
            cyc();
            n_checks++; if (cnt !== 6'(i + 1)) begin n_fail++; $display("FAIL fill_count i=%0d got %0d exp %0d", i, cnt, i + 1); end
            n_checks++; if (af !== (i + 1 >= 31)) begin n_fail++; $display("FAIL fill_af i=%0d got %b exp %b", i, af, (i + 1 >= 31)); end
            n_checks++; if (ful !== (i + 1 == 32)) begin n_fail++; $display("FAIL fill_full i=%0d got %b exp %b", i, ful, (i + 1 == 32)); end
        end
        din = 8'hAA;
        cyc();
        wr = 1'b0;
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL fill_overflow got %b exp 1", ovf); end
        n_checks++; if (cnt !== 6'd32) begin n_fail++; $display("FAIL fill_ovf_count got %0d exp 32", cnt); end
    endtask

    task automatic test_drain();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            rd = 1'b1;
            cyc();
            if (vld === 1'b1) pulses++;
            n_checks++; if (dout !== 8'(i)) begin n_fail++; $display("FAIL drain_data i=%0d got %h exp %h", i, dout, 8'(i)); end
            n_checks++; if (cnt !== 6'(31 - i)) begin n_fail++; $display("FAIL drain_count i=%0d got %0d exp %0d", i, cnt, 31 - i); end
            n_checks++; if (ae !== (31 - i <= 1)) begin n_fail++; $display("FAIL drain_ae i=%0d got %b exp %b", i, ae, (31 - i <= 1)); end
            n_checks++; if (emp !== (i == 31)) begin n_fail++; $display("FAIL drain_empty i=%0d got %b exp %b", i, emp, (i == 31)); end
        end
        n_checks++; if (pulses !== 32) begin n_fail++; $display("FAIL drain_valid_pulses got %0d exp 32", pulses); end
        cyc();
        rd = 1'b0;
        n_checks++; if ({udf, vld} !== 2'b10) begin n_fail++; $display("FAIL drain_underflow udf/vld got %b exp 10", {udf, vld}); end
        n_checks++; if (dout !== 8'h1F) begin n_fail++; $display("FAIL drain_hold got %h exp 1f", dout); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL drain_ovf_sticky got %b exp 1", ovf); end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        n_checks++; if ({ovf, udf} !== 2'b00) begin n_fail++; $display("FAIL clr_err got %b exp 00", {ovf, udf}); end
    endtask

    task automatic test_back_to_back();
        wr = 1'b1; rd = 1'b1; din = 8'h40;
        cyc();
        n_checks++; if (cnt !== 6'd1) begin n_fail++; $display("FAIL empty_rdwr_count got %0d exp 1", cnt); end
        n_checks++; if ({udf, vld} !== 2'b10) begin n_fail++; $display("FAIL empty_rdwr_udf got %b exp 10", {udf, vld}); end
        rd = 1'b0; wr = 1'b0; clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int i = 1; i < 5; i++) begin
            wr = 1'b1; din = 8'(8'h40 + i);
            cyc();
        end
        for (int k = 0; k < 10; k++) begin
            wr = 1'b1; rd = 1'b1; din = 8'(8'h45 + k);
            cyc();
            n_checks++; if (cnt !== 6'd5) begin n_fail++; $display("FAIL b2b_count k=%0d got %0d exp 5", k, cnt); end
            n_checks++; if ({vld, dout} !== {1'b1, 8'(8'h40 + k)}) begin n_fail++; $display("FAIL b2b_data k=%0d got %b/%h exp 1/%h", k, vld, dout, 8'(8'h40 + k)); end
        end
        wr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rd = 1'b1;
            cyc();
            n_checks++; if (dout !== 8'(8'h4A + k)) begin n_fail++; $display("FAIL b2b_tail k=%0d got %h exp %h", k, dout, 8'(8'h4A + k)); end
        end
        rd = 1'b0;
        for (int i = 0; i < 32; i++) begin
            wr = 1'b1; din = 8'(8'h80 + i);
            cyc();
        end
        rd = 1'b1; din = 8'hFF;
        cyc();
        wr = 1'b0;
        n_checks++; if (cnt !== 6'd31) begin n_fail++; $display("FAIL full_rdwr_count got %0d exp 31", cnt); end
        n_checks++; if ({ovf, dout} !== {1'b1, 8'h80}) begin n_fail++; $display("FAIL full_rdwr_ovf got %b/%h exp 1/80", ovf, dout); end
        for (int i = 1; i < 32; i++) begin
            cyc();
            n_checks++; if (dout !== 8'(8'h80 + i)) begin n_fail++; $display("FAIL full_drain i=%0d got %h exp %h", i, dout, 8'(8'h80 + i)); end
        end
        rd = 1'b0; clr = 1'b1;
        cyc();
        clr = 1'b0;
        n_checks++; if ({emp, ovf, udf} !== 3'b100) begin n_fail++; $display("FAIL full_rdwr_end got %b exp 100", {emp, ovf, udf}); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; din = 8'(i);
            cyc();
        end
        for (int i = 3; i < 100; i++) begin
            wr = 1'b1; rd = 1'b1; din = 8'(i);
            cyc();
            n_checks++; if (dout !== 8'(i - 3)) begin n_fail++; $display("FAIL wrap_data i=%0d got %h exp %h", i, dout, 8'(i - 3)); end
            n_checks++; if ({cnt, emp, ful, ae, af} !== {6'd3, 4'b0000}) begin n_fail++; $display("FAIL wrap_flags i=%0d got %0d/%b exp 3/0000", i, cnt, {emp, ful, ae, af}); end
        end
        wr = 1'b0;
        for (int i = 97; i < 100; i++) begin
            rd = 1'b1;
            cyc();
            n_checks++; if (dout !== 8'(i)) begin n_fail++; $display("FAIL wrap_tail i=%0d got %h exp %h", i, dout, 8'(i)); end
        end
        rd = 1'b0;
        cyc();
        n_checks++; if ({emp, udf, vld} !== 3'b100) begin n_fail++; $display("FAIL wrap_end got %b exp 100", {emp, udf, vld}); end
    endtask

    task automatic test_fwft();
        wr1 = 1'b1; din1 = 8'h5A;
        cyc();
        wr1 = 1'b0;
        n_checks++; if ({vld1, dout1} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL fwft_visible got %b/%h exp 1/5a", vld1, dout1); end
        cyc();
        n_checks++; if ({vld1, dout1, cnt1} !== {1'b1, 8'h5A, 6'd1}) begin n_fail++; $display("FAIL fwft_hold got %b/%h/%0d exp 1/5a/1", vld1, dout1, cnt1); end
        rd1 = 1'b1;
        cyc();
        rd1 = 1'b0;
        n_checks++; if ({emp1, vld1} !== 2'b10) begin n_fail++; $display("FAIL fwft_ack got %b exp 10", {emp1, vld1}); end
        wr1 = 1'b1; din1 = 8'h11;
        cyc();
        din1 = 8'h22;
        cyc();
        wr1 = 1'b0;
        n_checks++; if ({dout1, cnt1} !== {8'h11, 6'd2}) begin n_fail++; $display("FAIL fwft_head got %h/%0d exp 11/2", dout1, cnt1); end
        rd1 = 1'b1;
        cyc();
        n_checks++; if ({vld1, dout1} !== {1'b1, 8'h22}) begin n_fail++; $display("FAIL fwft_next got %b/%h exp 1/22", vld1, dout1); end
        cyc();
        rd1 = 1'b0;
        n_checks++; if ({emp1, vld1, udf1} !== 3'b100) begin n_fail++; $display("FAIL fwft_drained got %b exp 100", {emp1, vld1, udf1}); end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 11; i++) begin
            wr = 1'b1; din = 8'(8'hC0 + i);
            cyc();
        end
        wr = 1'b0; rd = 1'b1;
        cyc();
        rd = 1'b0;
        n_checks++; if ({cnt, vld} !== {6'd10, 1'b1}) begin n_fail++; $display("FAIL midop_pre got %0d/%b exp 10/1", cnt, vld); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if ({cnt, emp, vld} !== {6'd0, 2'b10}) begin n_fail++; $display("FAIL midop_async got %0d/%b exp 0/10", cnt, {emp, vld}); end
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL midop_dout got %h exp 00", dout); end
        @(negedge clk);
        rst = 1'b1;
        cyc();
        wr = 1'b1; din = 8'h11;
        cyc();
        wr = 1'b0; rd = 1'b1;
        cyc();
        rd = 1'b0;
        n_checks++; if ({vld, dout, cnt} !== {1'b1, 8'h11, 6'd0}) begin n_fail++; $display("FAIL midop_after got %b/%h/%0d exp 1/11/0", vld, dout, cnt); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        wr = 1'b0; rd = 1'b0; clr = 1'b0; din = 8'h00;
        wr1 = 1'b0; rd1 = 1'b0; clr1 = 1'b0; din1 = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_wrap();
        test_fwft();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
